pattern_gen_param: RTL and testbench
====================================

# pattern_gen_param

Parametrised video timing and test-pattern generator, the successor to the fixed 640x480 pattern block behind the HDMI encoder. Resolution, porch and sync widths, and colour depth are parameters. A runtime-selectable pattern mode (colour bars, grid, scrolling gradient, solid white) is sampled at frame boundaries. Outputs are registered RGB/HS/VS/DE plus a frame-end pulse, driving the TMDS encoder stage directly.

## Interface
- HPERIOD, 800, total pixels per line
- HFRONT, 16, horizontal front porch
- HWIDTH, 96, horizontal sync width
- HBACK, 48, horizontal back porch
- VPERIOD, 525, total lines per frame
- VFRONT, 10, vertical front porch
- VWIDTH, 2, vertical sync width
- VBACK, 33, vertical back porch
- CW, 8, bits per colour channel
- GRIDLOG, 5, log2 of grid pitch in pixels
- Derived: HACT = HPERIOD-HFRONT-HWIDTH-HBACK, VACT = VPERIOD-VFRONT-VWIDTH-VBACK. HACT must be a multiple of 8.
- CLK  in  1  pixel clock; single clock domain
- RST  in  1  asynchronous, active-low reset
- MODE  in  2  pattern select, sampled at frame start
- VGA_R, VGA_G, VGA_B  out  CW each  pixel colour
- VGA_HS, VGA_VS  out  1 each  syncs, active-low
- VGA_DE  out  1  display enable
- FRAME_END  out  1  one-cycle pulse on the last pixel of a frame

## Operation
- Counters HCNT 0..HPERIOD-1 and VCNT 0..VPERIOD-1. HCNT wraps to 0 and increments VCNT. VCNT wraps to 0 when HCNT wraps at VPERIOD-1.
- Active region: HCNT<HACT and VCNT<VACT. Everything else is blanking; RGB=0 in blanking.
- HS asserted (0) for HACT+HFRONT <= HCNT < HACT+HFRONT+HWIDTH.
- VS asserted (0) for VACT+VFRONT <= VCNT < VACT+VFRONT+VWIDTH.
- Mode register MREG loads MODE when HCNT=0 and VCNT=0. A change to MODE mid-frame has no effect until the next frame.
- Frame counter FCNT (CW bits) increments when HCNT=HPERIOD-1 and VCNT=VPERIOD-1, and wraps modulo 2^CW.
- Mode 0, colour bars:
  - Bar index i = HCNT/(HACT/8).
  - R full for i in {0,1,4,5}, G full for i in {0,1,2,3}, B full for i in {0,2,4,6}.
  - Resulting bar order: white, yellow, cyan, green, magenta, red, blue, black. Full = all ones.
- Mode 1, grid: white where HCNT[GRIDLOG-1:0]=0, VCNT[GRIDLOG-1:0]=0, HCNT=HACT-1 or VCNT=VACT-1; black elsewhere.
- Mode 2, gradient: R=G=B=(HCNT+FCNT) mod 2^CW, so the gradient scrolls left one pixel per frame.
- Mode 3, solid white.

## Timing
- Reset (RST=0, asynchronous):
  - HCNT=0, VCNT=0, FCNT=0, MREG=0.
  - RGB=0, HS=1, VS=1, DE=0, FRAME_END=0.
- Latency: counters at (h,v) in cycle t produce RGB/HS/VS/DE/FRAME_END for pixel (h,v) at the edge ending cycle t. That is one registered stage, and all outputs are aligned.
- First rising edge after RST deassert:
  - Outputs show pixel (0,0): DE=1; RGB all ones when MODE=0.
  - Counters advance to (1,0).
  - MREG loads MODE on that edge.
- FRAME_END is high for exactly one cycle, coincident with the output of pixel (HPERIOD-1, VPERIOD-1), and never during reset.
- Reset mid-frame: immediate return to reset values. The frame restarts at (0,0) with no partial pulse.
- Colour arithmetic is unsigned. Gradient addition truncates to CW bits.

## Structure
- Package pattern_pkg holds:
  - Mode encodings: MODE_BAR=0, MODE_GRID=1, MODE_GRAD=2, MODE_SOLID=3.
  - Bar colour table.
- Sub-module pattern_timing: HCNT/VCNT counters, active flags, raw syncs, frame-start and frame-end strobes, all parametrised.
- Top level: MREG, FCNT, pattern mux, output register stage.

## Test plan
- Default parameters, MODE=0, run 2 frames:
  - Line length 800 and frame length 420000 cycles.
  - HS low for 96 cycles starting 656 cycles after the line's first DE=1.
  - VS low for 2 lines.
  - DE=1 for 640x480 pixels per frame.
- MODE=0, line 0:
  - Output pixel 0 = all ones, pixel 80 = yellow (FF,FF,00), pixel 560 = black.
  - Boundaries land every 80 pixels.
- MODE switched 0 to 2 at pixel (100,200):
  - The remainder of the frame stays colour bars.
  - Next frame pixel (5,0) = 5+FCNT.
  - Following frame shows the value +1 (scroll).
- MODE=1, GRIDLOG=5:
  - Pixels (32,7) and (7,32) white; (33,33) black.
  - Column 639 and row 479 white.
- Assert RST low for 3 cycles at pixel (300,100):
  - Outputs reach reset values asynchronously and FRAME_END stays 0.
  - After release, the first output is pixel (0,0).
- Parameter override HPERIOD=1650, HFRONT=110, HWIDTH=40, HBACK=220, VPERIOD=750, VFRONT=5, VWIDTH=5, VBACK=20 (720p):
  - 1280x720 active pixels per frame.
  - FRAME_END period = 1237500 cycles.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared encodings for the parametrised video pattern generator: mode select,
// colour-bar table and the timing status bundle passed from counters to the mux.
package pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BAR   = 2'd0,
    MODE_GRID  = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  // {R,G,B} full-scale flags per bar, index 0 on the left:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_TAB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
    logic fstart;
    logic fend;
  } tim_t;

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return BAR_TAB[idx];
  endfunction

endpackage

// File: rtl/pattern_timing.sv
// Raster counters plus the combinational active/sync/frame strobes derived from
// them; everything here describes the pixel the counters currently point at.
module pattern_timing
  import pattern_pkg::*;
#(
  parameter int HPERIOD = 800,
  parameter int HFRONT  = 16,
  parameter int HWIDTH  = 96,
  parameter int HBACK   = 48,
  parameter int VPERIOD = 525,
  parameter int VFRONT  = 10,
  parameter int VWIDTH  = 2,
  parameter int VBACK   = 33,
  parameter int HW      = $clog2(HPERIOD + 1),
  parameter int VW      = $clog2(VPERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output tim_t          tim
);

  localparam int HACT = HPERIOD - HFRONT - HWIDTH - HBACK;
  localparam int VACT = VPERIOD - VFRONT - VWIDTH - VBACK;

  localparam logic [HW-1:0] H_LAST = HW'(HPERIOD - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(HACT);
  localparam logic [HW-1:0] H_SS   = HW'(HACT + HFRONT);
  localparam logic [HW-1:0] H_SE   = HW'(HACT + HFRONT + HWIDTH);
  localparam logic [VW-1:0] V_LAST = VW'(VPERIOD - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(VACT);
  localparam logic [VW-1:0] V_SS   = VW'(VACT + VFRONT);
  localparam logic [VW-1:0] V_SE   = VW'(VACT + VFRONT + VWIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_comb begin
    tim        = '0;
    tim.active = (hcnt < H_ACT) && (vcnt < V_ACT);
    tim.hs_n   = !((hcnt >= H_SS) && (hcnt < H_SE));
    tim.vs_n   = !((vcnt >= V_SS) && (vcnt < V_SE));
    tim.fstart = (hcnt == '0) && (vcnt == '0);
    tim.fend   = (hcnt == H_LAST) && (vcnt == V_LAST);
  end

endmodule

// File: rtl/pattern_gen_param.sv
// Video timing and test-pattern generator: mode/frame bookkeeping, pattern mux
// and a single output register stage feeding the TMDS encoder.
module pattern_gen_param
  import pattern_pkg::*;
#(
  parameter int HPERIOD = 800,
  parameter int HFRONT  = 16,
  parameter int HWIDTH  = 96,
  parameter int HBACK   = 48,
  parameter int VPERIOD = 525,
  parameter int VFRONT  = 10,
  parameter int VWIDTH  = 2,
  parameter int VBACK   = 33,
  parameter int CW      = 8,
  parameter int GRIDLOG = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [1:0]    MODE,
  output logic [CW-1:0] VGA_R,
  output logic [CW-1:0] VGA_G,
  output logic [CW-1:0] VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_DE,
  output logic          FRAME_END
);

  localparam int HW   = $clog2(HPERIOD + 1);
  localparam int VW   = $clog2(VPERIOD + 1);
  localparam int HACT = HPERIOD - HFRONT - HWIDTH - HBACK;
  localparam int VACT = VPERIOD - VFRONT - VWIDTH - VBACK;

  localparam logic [HW-1:0] BAR_W  = HW'(HACT / 8);
  localparam logic [HW-1:0] H_EDGE = HW'(HACT - 1);
  localparam logic [VW-1:0] V_EDGE = VW'(VACT - 1);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  tim_t          tim;

  pattern_timing #(
    .HPERIOD(HPERIOD), .HFRONT(HFRONT), .HWIDTH(HWIDTH), .HBACK(HBACK),
    .VPERIOD(VPERIOD), .VFRONT(VFRONT), .VWIDTH(VWIDTH), .VBACK(VBACK),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk  (CLK),
    .rst_n(RST),
    .hcnt (hcnt),
    .vcnt (vcnt),
    .tim  (tim)
  );

  mode_e         mreg;
  mode_e         mode_cur;
  logic [CW-1:0] fcnt;

  // The frame's first pixel already uses the freshly sampled MODE so that a
  // whole frame is rendered in one mode.
  assign mode_cur = tim.fstart ? mode_e'(MODE) : mreg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mreg <= MODE_BAR;
      fcnt <= '0;
    end else begin
      if (tim.fstart) mreg <= mode_cur;
      if (tim.fend)   fcnt <= fcnt + 1'b1;
    end
  end

  logic [2:0]    bar_idx;
  logic [2:0]    bar_c;
  logic          grid_on;
  logic [CW-1:0] grad;
  logic [CW-1:0] pix_r, pix_g, pix_b;

  assign bar_idx = 3'(hcnt / BAR_W);
  assign bar_c   = bar_rgb(bar_idx);
  assign grid_on = (hcnt[GRIDLOG-1:0] == '0) || (vcnt[GRIDLOG-1:0] == '0) ||
                   (hcnt == H_EDGE) || (vcnt == V_EDGE);
  assign grad    = CW'(hcnt) + fcnt;

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (tim.active) begin
      unique case (mode_cur)
        MODE_BAR: begin
          pix_r = {CW{bar_c[2]}};
          pix_g = {CW{bar_c[1]}};
          pix_b = {CW{bar_c[0]}};
        end
        MODE_GRID: begin
          pix_r = {CW{grid_on}};
          pix_g = {CW{grid_on}};
          pix_b = {CW{grid_on}};
        end
        MODE_GRAD: begin
          pix_r = grad;
          pix_g = grad;
          pix_b = grad;
        end
        MODE_SOLID: begin
          pix_r = '1;
          pix_g = '1;
          pix_b = '1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      VGA_HS    <= 1'b1;
      VGA_VS    <= 1'b1;
      VGA_DE    <= 1'b0;
      FRAME_END <= 1'b0;
    end else begin
      VGA_R     <= pix_r;
      VGA_G     <= pix_g;
      VGA_B     <= pix_b;
      VGA_HS    <= tim.hs_n;
      VGA_VS    <= tim.vs_n;
      VGA_DE    <= tim.active;
      FRAME_END <= tim.fend;
    end
  end

endmodule

// File: tb/tb_pattern_gen_param.sv
// Bench for pattern_gen_param on a reduced raster so that several whole frames fit
// in a short run; every output pixel is compared against a position-based model.
module tb_pattern_gen_param;

  localparam int HP = 80, HF = 4, HSW = 8, HB = 4;
  localparam int VP = 50, VF = 2, VSW = 2, VB = 4;
  localparam int CW = 5, GL = 3;
  localparam int HACT = HP - HF - HSW - HB;
  localparam int VACT = VP - VF - VSW - VB;
  localparam int FP = HP * VP;
  localparam int BW = HACT / 8;
  localparam int GP = 1 << GL;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [1:0]    MODE = 2'd0;
  logic [CW-1:0] VGA_R, VGA_G, VGA_B;
  logic          VGA_HS, VGA_VS, VGA_DE, FRAME_END;

  always #5 CLK = ~CLK;

  pattern_gen_param #(
    .HPERIOD(HP), .HFRONT(HF), .HWIDTH(HSW), .HBACK(HB),
    .VPERIOD(VP), .VFRONT(VF), .VWIDTH(VSW), .VBACK(VB),
    .CW(CW), .GRIDLOG(GL)
  ) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE), .FRAME_END(FRAME_END)
  );

  typedef struct packed {
    logic [CW-1:0] r, g, b;
    logic hs, vs, de, fe;
  } pix_t;

  pix_t act;
  assign act = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, FRAME_END};

  int tests = 0;
  int fails = 0;
  int k = -1;          // index of the pixel the outputs show, counted from reset release
  int mode_of[64];     // MODE seen at each frame's first edge

  logic [CW-1:0] ones = '1;
  logic [CW-1:0] zero = '0;

  // Expected output for the k-th pixel after reset, from raster arithmetic alone.
  function automatic pix_t model(input int kk);
    pix_t e;
    int p, h, v, fr, m, i, c;
    bit white;
    p = kk % FP; h = p % HP; v = p / HP; fr = kk / FP;
    m = (fr < 64) ? mode_of[fr] : 0;
    e = '0;
    e.hs = !(h >= HACT + HF && h < HACT + HF + HSW);
    e.vs = !(v >= VACT + VF && v < VACT + VF + VSW);
    e.de = (h < HACT) && (v < VACT);
    e.fe = (p == FP - 1);
    if (e.de) begin
      case (m)
        0: begin
          i = h / BW;
          e.r = (i == 0 || i == 1 || i == 4 || i == 5) ? ones : zero;
          e.g = (i <= 3) ? ones : zero;
          e.b = (i % 2 == 0) ? ones : zero;
        end
        1: begin
          white = (h % GP == 0) || (v % GP == 0) || (h == HACT - 1) || (v == VACT - 1);
          e.r = white ? ones : zero; e.g = e.r; e.b = e.r;
        end
        2: begin
          c = (h + fr) % (1 << CW);
          e.r = CW'(c); e.g = CW'(c); e.b = CW'(c);
        end
        default: begin
          e.r = ones; e.g = ones; e.b = ones;
        end
      endcase
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    k++;
    if (k % FP == 0 && k / FP < 64) mode_of[k / FP] = int'(MODE);
    #1;
  endtask

  task automatic test_reset();
    pix_t e;
    repeat (2) @(posedge CLK);
    #1;
    e = '0; e.hs = 1'b1; e.vs = 1'b1;
    tests++; if (VGA_R !== zero) begin fails++; $display("FAIL reset_r got=%h exp=%h", VGA_R, zero); end
    tests++; if (VGA_G !== zero) begin fails++; $display("FAIL reset_g got=%h exp=%h", VGA_G, zero); end
    tests++; if (VGA_B !== zero) begin fails++; $display("FAIL reset_b got=%h exp=%h", VGA_B, zero); end
    tests++; if (VGA_HS !== 1'b1) begin fails++; $display("FAIL reset_hs got=%b exp=1", VGA_HS); end
    tests++; if (VGA_VS !== 1'b1) begin fails++; $display("FAIL reset_vs got=%b exp=1", VGA_VS); end
    tests++; if (VGA_DE !== 1'b0) begin fails++; $display("FAIL reset_de got=%b exp=0", VGA_DE); end
    tests++; if (FRAME_END !== 1'b0) begin fails++; $display("FAIL reset_fe got=%b exp=0", FRAME_END); end
    MODE = 2'd0;
    @(negedge CLK);
    RST = 1'b1;
    k = -1;
  endtask

  // Frame 0 in colour bars; MODE flips to gradient mid-frame and must not show.
  task automatic test_bars();
    pix_t e;
    int de_cnt = 0, hs_cnt = 0, hs_first = -1, vs_cnt = 0, fe_cnt = 0;
    for (int n = 0; n < FP; n++) begin
      tick();
      e = model(k);
      tests++;
      if (act !== e) begin fails++; $display("FAIL bars_pix k=%0d got=%h exp=%h", k, act, e); end
      if (k == 0) begin
        tests++;
        if ({VGA_R, VGA_G, VGA_B, VGA_DE} !== {ones, ones, ones, 1'b1}) begin
          fails++; $display("FAIL bars_first got=%h%h%h de=%b exp=white de=1", VGA_R, VGA_G, VGA_B, VGA_DE);
        end
      end
      if (k == BW) begin
        tests++;
        if ({VGA_R, VGA_G, VGA_B} !== {ones, ones, zero}) begin
          fails++; $display("FAIL bars_yellow got=%h%h%h exp=%h%h%h", VGA_R, VGA_G, VGA_B, ones, ones, zero);
        end
      end
      if (k == 7 * BW) begin
        tests++;
        if ({VGA_R, VGA_G, VGA_B} !== {zero, zero, zero}) begin
          fails++; $display("FAIL bars_black got=%h%h%h exp=000", VGA_R, VGA_G, VGA_B);
        end
      end
      if (k == 30 * HP + 20) MODE = 2'd2;
      de_cnt += int'(VGA_DE);
      if (k < HP && !VGA_HS) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
      end
      vs_cnt += int'(!VGA_VS);
      fe_cnt += int'(FRAME_END);
    end
    tests++; if (de_cnt != HACT * VACT) begin fails++; $display("FAIL de_count got=%0d exp=%0d", de_cnt, HACT * VACT); end
    tests++; if (hs_first != HACT + HF) begin fails++; $display("FAIL hs_offset got=%0d exp=%0d", hs_first, HACT + HF); end
    tests++; if (hs_cnt != HSW) begin fails++; $display("FAIL hs_width got=%0d exp=%0d", hs_cnt, HSW); end
    tests++; if (vs_cnt != VSW * HP) begin fails++; $display("FAIL vs_width got=%0d exp=%0d", vs_cnt, VSW * HP); end
    tests++; if (fe_cnt != 1) begin fails++; $display("FAIL fe_count got=%0d exp=1", fe_cnt); end
  endtask

  // Two gradient frames: value at (5,0) is 5+frame and steps by one per frame.
  task automatic test_grad_scroll();
    pix_t e;
    logic [CW-1:0] g;
    int last_fe = -1, last_hs_fall = -1;
    logic hs_prev = 1'b1;
    for (int n = 0; n < 2 * FP; n++) begin
      tick();
      e = model(k);
      tests++;
      if (act !== e) begin fails++; $display("FAIL grad_pix k=%0d got=%h exp=%h", k, act, e); end
      if (k % FP == 5) begin
        g = CW'(5 + k / FP);
        tests++;
        if ({VGA_R, VGA_G, VGA_B} !== {g, g, g}) begin
          fails++; $display("FAIL grad_scroll frame=%0d got=%h exp=%h", k / FP, VGA_R, g);
        end
      end
      if (hs_prev && !VGA_HS) begin
        if (last_hs_fall >= 0) begin
          tests++;
          if (k - last_hs_fall != HP) begin fails++; $display("FAIL line_len got=%0d exp=%0d", k - last_hs_fall, HP); end
        end
        last_hs_fall = k;
      end
      hs_prev = VGA_HS;
      if (FRAME_END) begin
        if (last_fe >= 0) begin
          tests++;
          if (k - last_fe != FP) begin fails++; $display("FAIL frame_len got=%0d exp=%0d", k - last_fe, FP); end
        end
        last_fe = k;
      end
    end
  endtask

  task automatic test_grid();
    pix_t e;
    int p;
    MODE = 2'd1;
    for (int n = 0; n < FP; n++) begin
      tick();
      e = model(k);
      tests++;
      if (act !== e) begin fails++; $display("FAIL grid_pix k=%0d got=%h exp=%h", k, act, e); end
      p = k % FP;
      if (p == 7 * HP + GP || p == GP * HP + 7 || p == 10 * HP + HACT - 1 || p == (VACT - 1) * HP + 10) begin
        tests++;
        if (VGA_R !== ones) begin fails++; $display("FAIL grid_white p=%0d got=%h exp=%h", p, VGA_R, ones); end
      end
      if (p == (GP + 1) * HP + GP + 1) begin
        tests++;
        if (VGA_R !== zero) begin fails++; $display("FAIL grid_black p=%0d got=%h exp=%h", p, VGA_R, zero); end
      end
    end
  endtask

  task automatic test_solid();
    pix_t e;
    int p;
    MODE = 2'd3;
    for (int n = 0; n < FP; n++) begin
      tick();
      e = model(k);
      tests++;
      if (act !== e) begin fails++; $display("FAIL solid_pix k=%0d got=%h exp=%h", k, act, e); end
      p = k % FP;
      if (p == (VACT - 1) * HP + HACT - 1) begin
        tests++;
        if ({VGA_R, VGA_G, VGA_B} !== {ones, ones, ones}) begin fails++; $display("FAIL solid_last got=%h exp=%h", VGA_R, ones); end
      end
      if (p == HACT) begin
        tests++;
        if ({VGA_R, VGA_G, VGA_B, VGA_DE} !== {zero, zero, zero, 1'b0}) begin
          fails++; $display("FAIL solid_blank got=%h de=%b exp=0 de=0", VGA_R, VGA_DE);
        end
      end
      if (n == FP / 2) MODE = 2'd0;
    end
  endtask

  task automatic test_reset_mid();
    pix_t e, r;
    MODE = 2'd0;
    r = '0; r.hs = 1'b1; r.vs = 1'b1;
    for (int n = 0; n < 20 * HP + 31; n++) begin
      tick();
      e = model(k);
      tests++;
      if (act !== e) begin fails++; $display("FAIL pre_reset_pix k=%0d got=%h exp=%h", k, act, e); end
    end
    #2;
    RST = 1'b0;
    #1;
    tests++;
    if (act !== r) begin fails++; $display("FAIL async_reset got=%h exp=%h", act, r); end
    for (int n = 0; n < 3; n++) begin
      @(posedge CLK); #1;
      tests++;
      if (act !== r) begin fails++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", n, act, r); end
    end
    @(negedge CLK);
    RST = 1'b1;
    k = -1;
    for (int n = 0; n < FP; n++) begin
      tick();
      e = model(k);
      tests++;
      if (act !== e) begin fails++; $display("FAIL post_reset_pix k=%0d got=%h exp=%h", k, act, e); end
      if (k == 0) begin
        tests++;
        if ({VGA_R, VGA_G, VGA_B, VGA_DE, FRAME_END} !== {ones, ones, ones, 1'b1, 1'b0}) begin
          fails++; $display("FAIL restart_pix0 got=%h de=%b fe=%b exp=white de=1 fe=0", VGA_R, VGA_DE, FRAME_END);
        end
      end
    end
  endtask

  task automatic test_random_modes();
    pix_t e;
    for (int n = 0; n < 3 * FP; n++) begin
      tick();
      e = model(k);
      tests++;
      if (act !== e) begin fails++; $display("FAIL rand_pix k=%0d got=%h exp=%h", k, act, e); end
      if ($urandom_range(0, 299) == 0) MODE = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_grad_scroll();
    test_grid();
    test_solid();
    test_reset_mid();
    test_random_modes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
